// File: rtl/fc_argmax.sv
// Serial argmax over a snapshot of the FC layer's binary32 output vector.
// One element is compared per clock using a sign/magnitude ordering; NaNs are skipped.
module fc_argmax #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_NODES   = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_WIDTH*NUM_NODES-1:0] input_fc,
  output logic                            busy,
  output logic                            done,
  output logic [INDEX_WIDTH-1:0]          max_index,
  output logic [DATA_WIDTH-1:0]           max_value,
  output logic                            nan_only
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [DATA_WIDTH-1:0]  QNAN = DATA_WIDTH'(32'h7FC0_0000);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_NODES - 1);

  logic [0:0]                      state_q, state_d;
  logic [INDEX_WIDTH-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH*NUM_NODES-1:0] snap_q, snap_d;
  logic                            best_valid_q, best_valid_d;
  logic [DATA_WIDTH-1:0]           best_val_q, best_val_d;
  logic [INDEX_WIDTH-1:0]          best_idx_q, best_idx_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [INDEX_WIDTH-1:0]          max_index_q, max_index_d;
  logic [DATA_WIDTH-1:0]           max_value_q, max_value_d;
  logic                            nan_only_q, nan_only_d;

  logic [DATA_WIDTH-1:0]  elem;
  logic                   elem_nan;
  logic                   take;
  logic [DATA_WIDTH-1:0]  cand_val;
  logic [INDEX_WIDTH-1:0] cand_idx;
  logic                   cand_valid;

  // Strict a > b on binary32 bit patterns; +0 and -0 are treated as equal.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                              input logic [DATA_WIDTH-1:0] b);
    logic a_zero;
    logic b_zero;
    a_zero = (a[DATA_WIDTH-2:0] == '0);
    b_zero = (b[DATA_WIDTH-2:0] == '0);
    if (a_zero && b_zero)
      return 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      return ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
    else
      return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
  endfunction

  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      if (cnt_q == INDEX_WIDTH'(i))
        elem = snap_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    elem_nan   = (&elem[30:23]) && (|elem[22:0]);
    take       = !elem_nan && (!best_valid_q || gt(elem, best_val_q));
    cand_val   = take ? elem  : best_val_q;
    cand_idx   = take ? cnt_q : best_idx_q;
    cand_valid = best_valid_q | take;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    best_valid_d = best_valid_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    max_index_d  = max_index_q;
    max_value_d  = max_value_q;
    nan_only_d   = nan_only_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d      = SCAN;
        snap_d       = input_fc;
        cnt_d        = '0;
        best_valid_d = 1'b0;
        // Seeding best with a quiet NaN at index 0 yields the all-NaN result for free.
        best_val_d   = QNAN;
        best_idx_d   = '0;
        busy_d       = 1'b1;
      end
    end else begin
      best_valid_d = cand_valid;
      best_val_d   = cand_val;
      best_idx_d   = cand_idx;
      cnt_d        = cnt_q + INDEX_WIDTH'(1);
      if (cnt_q == LAST) begin
        max_index_d = cand_idx;
        max_value_d = cand_val;
        nan_only_d  = ~cand_valid;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      snap_q       <= '0;
      best_valid_q <= 1'b0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      max_index_q  <= '0;
      max_value_q  <= '0;
      nan_only_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      best_valid_q <= best_valid_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      max_index_q  <= max_index_d;
      max_value_q  <= max_value_d;
      nan_only_q   <= nan_only_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign max_index = max_index_q;
  assign max_value = max_value_q;
  assign nan_only  = nan_only_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: directed and random vectors against a real-valued argmax model.
module tb_fc_argmax;

  localparam int W     = 32;
  localparam int N     = 32;
  localparam int IW    = 5;
  localparam int BOUND = 100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [W*N-1:0]  input_fc;
  logic            busy;
  logic            done;
  logic [IW-1:0]   max_index;
  logic [W-1:0]    max_value;
  logic            nan_only;

  logic [31:0] vec [N];
  logic [IW-1:0] exp_idx;
  logic [31:0]   exp_val;
  logic          exp_nan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_argmax #(.DATA_WIDTH(W), .NUM_NODES(N), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .input_fc(input_fc),
    .busy(busy), .done(done), .max_index(max_index), .max_value(max_value),
    .nan_only(nan_only)
  );

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  // Numeric value of a binary32 pattern; infinities map beyond the finite range.
  function automatic real to_real(input logic [31:0] b);
    int  e;
    real m;
    real mag;
    e = int'(b[30:23]);
    m = real'(b[22:0]) / 8388608.0;
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = m * (2.0 ** (-126));
    else             mag = (1.0 + m) * (2.0 ** (e - 127));
    return b[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] f_of_int(input int unsigned i);
    int e;
    if (i == 0) return 32'd0;
    e = 31;
    while (i[e] == 1'b0) e--;
    return {1'b0, 8'(e + 127), 23'(i << (23 - e))};
  endfunction

  function automatic logic [31:0] rand_elem();
    logic [31:0] sp [6];
    logic [31:0] v;
    sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h8000_0000,
           32'h7FC0_0000, 32'h7F80_0001};
    case ($urandom_range(0, 5))
      0:       v = $urandom;
      1:       v = sp[$urandom_range(0, 5)];
      default: begin
        v = f_of_int($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) v[31] = 1'b1;
      end
    endcase
    return v;
  endfunction

  task automatic model();
    logic valid;
    valid   = 1'b0;
    exp_idx = '0;
    exp_val = QNAN;
    for (int i = 0; i < N; i++) begin
      if (!is_nan(vec[i]) && (!valid || to_real(vec[i]) > to_real(exp_val))) begin
        valid   = 1'b1;
        exp_idx = IW'(i);
        exp_val = vec[i];
      end
    end
    exp_nan = !valid;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) input_fc[i*W +: W] = vec[i];
  endtask

  task automatic start_scan();
    apply();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done after the start edge; cycles reaches BOUND on timeout.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = busy ? 1 : 0;
    while (cycles < BOUND) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; input_fc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset done got %b want 0", done); end
    checks++; if (max_index !== '0)   begin errors++; $display("FAIL reset max_index got %0d want 0", max_index); end
    checks++; if (max_value !== '0)   begin errors++; $display("FAIL reset max_value got %h want 0", max_value); end
    checks++; if (nan_only !== 1'b0)  begin errors++; $display("FAIL reset nan_only got %b want 0", nan_only); end
  endtask

  task automatic test_ascending();
    int cyc, bcyc;
    for (int i = 0; i < N; i++) vec[i] = f_of_int(i);
    model();
    start_scan();
    wait_done(cyc, bcyc);
    checks++; if (cyc !== 32)             begin errors++; $display("FAIL asc latency got %0d want 32", cyc); end
    checks++; if (bcyc !== 32)            begin errors++; $display("FAIL asc busy_cycles got %0d want 32", bcyc); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL asc busy_at_done got %b want 0", busy); end
    checks++; if (max_index !== exp_idx)  begin errors++; $display("FAIL asc max_index got %0d want %0d", max_index, exp_idx); end
    checks++; if (max_value !== 32'h41F8_0000) begin errors++; $display("FAIL asc max_value got %h want 41f80000", max_value); end
    checks++; if (nan_only !== 1'b0)      begin errors++; $display("FAIL asc nan_only got %b want 0", nan_only); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL asc done_width got %b want 0", done); end
    checks++; if (max_index !== exp_idx)  begin errors++; $display("FAIL asc hold got %0d want %0d", max_index, exp_idx); end
  endtask

  // Runs the current vec and compares the result triple against the model.
  task automatic test_vector(input string tag);
    int cyc, bcyc;
    model();
    start_scan();
    wait_done(cyc, bcyc);
    checks++; if (cyc !== 32)            begin errors++; $display("FAIL %s latency got %0d want 32", tag, cyc); end
    checks++; if (max_index !== exp_idx) begin errors++; $display("FAIL %s max_index got %0d want %0d", tag, max_index, exp_idx); end
    checks++; if (max_value !== exp_val) begin errors++; $display("FAIL %s max_value got %h want %h", tag, max_value, exp_val); end
    checks++; if (nan_only !== exp_nan)  begin errors++; $display("FAIL %s nan_only got %b want %b", tag, nan_only, exp_nan); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < N; i++) vec[i] = 32'hBF80_0000;
    vec[7] = 32'h3F00_0000; vec[20] = 32'h3F00_0000;
    test_vector("tie");
    for (int i = 0; i < N; i++) vec[i] = f_of_int(i + 1) | 32'h8000_0000;
    test_vector("all_neg");
    vec[5] = 32'h8000_0000; vec[9] = 32'h0000_0000;
    test_vector("signed_zero");
    for (int i = 0; i < N; i++) vec[i] = 32'h3F80_0000;
    vec[0] = QNAN; vec[3] = 32'h7F80_0000;
    test_vector("nan_inf");
    for (int i = 0; i < N; i++) vec[i] = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
    test_vector("all_nan");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) vec[i] = rand_elem();
      test_vector($sformatf("rand%0d", t));
    end
  endtask

  task automatic test_snapshot();
    int pulses, first;
    for (int i = 0; i < N; i++) vec[i] = f_of_int($urandom_range(0, 20));
    model();
    start_scan();
    pulses = 0; first = -1;
    for (int e = 1; e <= 70; e++) begin
      if (e == 10) begin
        for (int i = 0; i < N; i++) vec[i] = 32'h7F80_0000;
        apply();
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin pulses++; if (first < 0) first = e; end
    end
    checks++; if (pulses !== 1)          begin errors++; $display("FAIL snap done_pulses got %0d want 1", pulses); end
    checks++; if (first !== 32)          begin errors++; $display("FAIL snap done_edge got %0d want 32", first); end
    checks++; if (max_index !== exp_idx) begin errors++; $display("FAIL snap max_index got %0d want %0d", max_index, exp_idx); end
    checks++; if (max_value !== exp_val) begin errors++; $display("FAIL snap max_value got %h want %h", max_value, exp_val); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL snap busy_after got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    for (int i = 0; i < N; i++) vec[i] = f_of_int(i);
    start_scan();
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rstmid done got %b want 0", done); end
    checks++; if (max_index !== '0)  begin errors++; $display("FAIL rstmid max_index got %0d want 0", max_index); end
    checks++; if (max_value !== '0)  begin errors++; $display("FAIL rstmid max_value got %h want 0", max_value); end
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
    checks++; if (pulses !== 0)      begin errors++; $display("FAIL rstmid stray_done got %0d want 0", pulses); end
    for (int i = 0; i < N; i++) vec[i] = rand_elem();
    test_vector("after_rst");
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    for (int i = 0; i < N; i++) vec[i] = rand_elem();
    model();
    start_scan();
    wait_done(cyc, bcyc);
    checks++; if (max_index !== exp_idx) begin errors++; $display("FAIL b2b first_index got %0d want %0d", max_index, exp_idx); end
    for (int i = 0; i < N; i++) vec[i] = rand_elem();
    vec[$urandom_range(0, N-1)] = 32'h7F80_0000;
    model();
    start_scan();
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL b2b accepted got busy=%b want 1", busy); end
    wait_done(cyc, bcyc);
    checks++; if (cyc !== 32)            begin errors++; $display("FAIL b2b latency got %0d want 32", cyc); end
    checks++; if (max_index !== exp_idx) begin errors++; $display("FAIL b2b max_index got %0d want %0d", max_index, exp_idx); end
    checks++; if (max_value !== exp_val) begin errors++; $display("FAIL b2b max_value got %h want %h", max_value, exp_val); end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_directed();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
